// File: rtl/v4l2_ctrl_name_pkg.sv
// v4l2_ctrl_name_pkg: shared FSM state, table entry type and default geometry for the control-name lookup
package v4l2_ctrl_name_pkg;
  localparam int NUM_ENTRIES_D = 64;
  localparam int LANES_D = 4;
  localparam int ID_W_D = 32;
  localparam int PTR_W_D = 64;
  localparam int IDX_W = $clog2(NUM_ENTRIES_D);
  localparam int GROUPS = NUM_ENTRIES_D / LANES_D;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  typedef struct packed {
    logic valid;
    logic [ID_W_D-1:0] id;
    logic [PTR_W_D-1:0] ptr;
  } entry_t;
endpackage

// File: rtl/v4l2_ctrl_name_match.sv
// v4l2_ctrl_name_match: LANES-wide id comparator with lowest-lane priority select
module v4l2_ctrl_name_match #(
  parameter int LANES = 4,
  parameter int ID_W = 32,
  parameter int PTR_W = 64
) (
  input  logic [ID_W-1:0]  key,
  input  logic [LANES-1:0] vld,
  input  logic [ID_W-1:0]  ids [LANES],
  input  logic [PTR_W-1:0] ptrs [LANES],
  output logic             match,
  output logic [PTR_W-1:0] sel_ptr
);
  always_comb begin
    match = 1'b0;
    sel_ptr = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (vld[i] && ids[i] == key) begin
        match = 1'b1;
        sel_ptr = ptrs[i];
      end
  end
endmodule

// File: rtl/v4l2_ctrl_name_lookup.sv
// v4l2_ctrl_name_lookup: id -> name-pointer table scan with call/return handshake; V4L2_CTRL_NAME_CACHE_EN adds a last-result cache
module v4l2_ctrl_name_lookup import v4l2_ctrl_name_pkg::*; #(
  parameter int NUM_ENTRIES = NUM_ENTRIES_D,
  parameter int LANES = LANES_D,
  parameter int ID_W = ID_W_D,
  parameter int PTR_W = PTR_W_D,
  parameter logic [PTR_W-1:0] DEFAULT_PTR = '0
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           start,
  output logic                           busy,
  input  logic [ID_W-1:0]                id,
  output logic                           done,
  input  logic                           stall,
  output logic [PTR_W-1:0]               returndata,
  output logic                           hit,
  input  logic                           tbl_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] tbl_idx,
  input  logic [ID_W-1:0]                tbl_id,
  input  logic [PTR_W-1:0]               tbl_ptr,
  input  logic                           tbl_clr
);
  localparam int IX_W = $clog2(NUM_ENTRIES);
  state_t state;
  logic [NUM_ENTRIES-1:0] vld;
  logic [ID_W-1:0] tid [NUM_ENTRIES];
  logic [PTR_W-1:0] tptr [NUM_ENTRIES];
  logic [ID_W-1:0] key;
  logic [IX_W-1:0] idx;
  logic [LANES-1:0] l_vld;
  logic [ID_W-1:0] l_id [LANES];
  logic [PTR_W-1:0] l_ptr [LANES];
  logic match, last, wr_ok, chit, c_hv;
  logic [PTR_W-1:0] sel_ptr, c_ptr;
  assign wr_ok = state == IDLE;
  assign last = idx == IX_W'(NUM_ENTRIES - LANES);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign l_vld[l] = vld[idx + IX_W'(l)];
    assign l_id[l] = tid[idx + IX_W'(l)];
    assign l_ptr[l] = tptr[idx + IX_W'(l)];
  end
  v4l2_ctrl_name_match #(.LANES(LANES), .ID_W(ID_W), .PTR_W(PTR_W)) u_match (
    .key(key), .vld(l_vld), .ids(l_id), .ptrs(l_ptr), .match(match), .sel_ptr(sel_ptr)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) vld <= '0;
    else if (wr_ok && tbl_clr) vld <= '0;
    else if (wr_ok && tbl_we) vld[tbl_idx] <= 1'b1;
  always_ff @(posedge clock)
    if (wr_ok && tbl_we && !tbl_clr) begin
      tid[tbl_idx] <= tbl_id;
      tptr[tbl_idx] <= tbl_ptr;
    end
`ifdef V4L2_CTRL_NAME_CACHE_EN
  logic c_vld;
  logic [ID_W-1:0] c_id;
  // a same-cycle table write must win over a stale cached answer
  assign chit = c_vld && c_id == id && !tbl_we && !tbl_clr;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      c_vld <= 1'b0;
      c_id <= '0;
      c_ptr <= '0;
      c_hv <= 1'b0;
    end else if (wr_ok && (tbl_we || tbl_clr)) c_vld <= 1'b0;
    else if (state == RESP) begin
      c_vld <= 1'b1;
      c_id <= key;
      c_ptr <= returndata;
      c_hv <= hit;
    end
`else
  assign chit = 1'b0;
  assign c_ptr = '0;
  assign c_hv = 1'b0;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hit <= 1'b0;
      returndata <= '0;
      key <= '0;
      idx <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          key <= id;
          idx <= '0;
          busy <= 1'b1;
          state <= chit ? RESP : SCAN;
          done <= chit;
          if (chit) begin
            returndata <= c_ptr;
            hit <= c_hv;
          end
        end
        SCAN: if (match || last) begin
          state <= RESP;
          done <= 1'b1;
          returndata <= match ? sel_ptr : DEFAULT_PTR;
          hit <= match;
        end else idx <= idx + IX_W'(LANES);
        RESP: if (!stall) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
          hit <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/v4l2_ctrl_name_lookup.md
Name: v4l2_ctrl_name_lookup

Overview:
- Parametrised successor to the single-call control-name accessor.
- Holds a runtime-loadable table of (control id, name pointer) entries.
- Each call scans the table LANES entries per cycle and returns the matching name pointer, or DEFAULT_PTR on a miss.
- Uses the same call/return valid-stall handshake as the other HLS-style components, so it can drop into the control-path component chain.

Parameters:
- NUM_ENTRIES, 64: table depth; must be a multiple of LANES.
- LANES, 4: entries compared per scan cycle; must be a power of two.
- ID_W, 32: control id width.
- PTR_W, 64: name pointer width (returndata width).
- DEFAULT_PTR, 0: value returned on a miss.

Ports:
- clock  in  1  clock.clk
- resetn  in  1  reset.reset_n; asynchronous, active-low.
- start  in  1  call.valid
- busy  out  1  call.stall
- id  in  ID_W  call data: control id to look up.
- done  out  1  return.valid
- stall  in  1  return.stall
- returndata  out  PTR_W  matched name pointer, or DEFAULT_PTR.
- hit  out  1  returndata came from a table match; valid while done=1.
- tbl_we  in  1  table write strobe.
- tbl_idx  in  clog2(NUM_ENTRIES)  table entry written.
- tbl_id  in  ID_W  id stored at tbl_idx.
- tbl_ptr  in  PTR_W  pointer stored at tbl_idx.
- tbl_clr  in  1  clears all valid bits.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset state:
  - FSM in IDLE; all valid bits cleared.
  - busy=0, done=0, hit=0, returndata=0.
- FSM states:
  - IDLE: busy=0. On start=1, latch id, set scan index=0, go to SCAN.
  - SCAN: busy=1. Each cycle compare entries idx..idx+LANES-1; an entry matches if valid && stored id == latched id.
    - Any match: capture the pointer of the lowest-index matching entry, hit=1, go to RESP.
    - No match and idx+LANES == NUM_ENTRIES: returndata=DEFAULT_PTR, hit=0, go to RESP.
    - Otherwise: idx += LANES.
  - RESP: busy=1, done=1. returndata and hit stay stable while stall=1. When stall=0 the result is consumed; go to IDLE.
- Only one call is in flight; busy drops the cycle after consumption.
- Latency, start to done:
  - Hit in lane group k: k+2 cycles.
  - Miss: NUM_ENTRIES/LANES+1 cycles.
- Duplicate ids in the table: lowest index wins.
- Table writes:
  - Accepted only in IDLE; ignored in SCAN and RESP.
  - tbl_we sets the entry's valid bit and writes its id and pointer.
  - tbl_clr clears every valid bit. If tbl_clr and tbl_we are both high, tbl_clr wins.
- start together with tbl_we or tbl_clr in the same IDLE cycle: the write lands first, and the scan sees the updated table.
- start while busy=1: ignored. Callers must hold start until busy=0.
- resetn asserted in any state aborts the call immediately. Outputs and valid bits return to reset values; no done is produced.

Optional Feature:
- Macro: V4L2_CTRL_NAME_CACHE_EN.
- When defined: a one-entry last-result cache holds (id, ptr, hit, valid).
  - A start in IDLE whose id equals the cached id with cache valid=1 goes straight to RESP next cycle: 1-cycle latency, cached ptr and hit.
  - Every RESP updates the cache.
  - Any table write or clear invalidates the cache.
  - Reset clears the cache.
- When undefined: no cache logic; every call scans the table.

Decomposition:
- Package v4l2_ctrl_name_pkg holds:
  - the FSM state enum (IDLE, SCAN, RESP);
  - the entry struct {valid, id, ptr};
  - the localparams IDX_W = clog2(NUM_ENTRIES) and GROUPS = NUM_ENTRIES/LANES.
- Sub-module v4l2_ctrl_name_match: combinational LANES-wide comparator plus lowest-index priority encoder, producing match and sel_ptr.

Test Plan:
- Reset, then load id 0x00980900 -> ptr 0x1000 at idx 0; start id=0x00980900 -> done in 2 cycles, returndata=0x1000, hit=1.
- Load id 0x00980901 at idx 63 (LANES=4) -> done 17 cycles after start, hit=1. Look up unloaded id 0x1234 -> done 17 cycles after start, returndata=0, hit=0.
- Hold stall=1 for 5 cycles during RESP -> done and returndata stable, busy=1; on stall=0, next cycle busy=0.
- Same id at idx 2 (ptr 0xA) and idx 6 (ptr 0xB) -> returns 0xA. tbl_we pulsed during SCAN -> table unchanged.
- tbl_clr then look up a previously loaded id -> miss. start with tbl_we in the same cycle -> the new entry is found.
- Drop resetn mid-SCAN -> done never asserts, busy=0. With V4L2_CTRL_NAME_CACHE_EN defined, a repeat lookup -> done after 1 cycle; after a table write, the same lookup rescans.
